// File: rtl/eq_band_sched.sv
// Per-sample scheduler sharing one band-filter engine across all EQ bands and both channels.
// Optional per-band muting is compiled in when BAND_MUTE_EN is defined.
module eq_band_sched #(
  parameter int unsigned NUM_BANDS = 5,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  output logic        eng_start,
  output logic [2:0]  eng_band,
  output logic        eng_chan,
  output logic [15:0] eng_sample,
  input  logic        eng_done,
  input  logic [15:0] eng_result,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        out_rdy,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
`ifdef BAND_MUTE_EN
  ,
  input  logic [7:0]  band_mute
`endif
);

  localparam int unsigned SMP_W = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned BND_W = 3;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Lowest unmuted band index >= from; NUM_BANDS when none remain.
  function automatic logic [IDX_W-1:0] find_band(input logic [7:0] mute, input logic [IDX_W-1:0] from);
    logic [IDX_W-1:0] res;
    logic             hit;
    res = IDX_W'(NUM_BANDS);
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!hit && (i < NUM_BANDS) && (IDX_W'(i) >= from) && !mute[3'(i)]) begin
        res = IDX_W'(i);
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [SMP_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > 20'sd32767)       return 16'h7FFF;
    else if (a < -20'sd32768) return 16'h8000;
    else                      return a[SMP_W-1:0];
  endfunction

  state_t                   r_state, w_state_n;
  logic                     r_valid;
  logic [SMP_W-1:0]         r_lft_s, r_rht_s, w_lft_s_n, w_rht_s_n;
  logic signed [ACC_W-1:0]  r_acc_l, r_acc_r, w_acc_l_n, w_acc_r_n;
  logic [BND_W-1:0]         r_band, w_band_n;
  logic                     r_chan, w_chan_n;
  logic [CNT_W-1:0]         r_cnt, w_cnt_n;
  logic [7:0]               r_mute, w_mute_n, w_mute_in;
  logic                     r_eng_start, w_start_n;
  logic [SMP_W-1:0]         r_eng_sample, w_eng_sample_n;
  logic [SMP_W-1:0]         r_lft_out, r_rht_out, w_lft_out_n, w_rht_out_n;
  logic                     r_out_rdy, w_out_rdy_n;
  logic                     r_busy, w_busy_n;
  logic                     r_overrun, w_overrun_n;
  logic                     r_tmo, w_tmo_n;
  logic                     w_frame;
  logic                     w_adv;
  logic signed [ACC_W-1:0]  w_res_ext;
  logic [IDX_W-1:0]         w_first, w_next;

`ifdef BAND_MUTE_EN
  assign w_mute_in = band_mute;
`else
  assign w_mute_in = 8'h00;
`endif

  assign w_frame   = valid & ~r_valid;
  assign w_res_ext = {{(ACC_W-SMP_W){eng_result[SMP_W-1]}}, eng_result};
  assign w_first   = find_band(w_mute_in, IDX_W'(0));
  assign w_next    = find_band(r_mute, IDX_W'(r_band) + IDX_W'(1));

  assign eng_start   = r_eng_start;
  assign eng_band    = r_band;
  assign eng_chan    = r_chan;
  assign eng_sample  = r_eng_sample;
  assign lft_out     = r_lft_out;
  assign rht_out     = r_rht_out;
  assign out_rdy     = r_out_rdy;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign timeout_err = r_tmo;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state, job sequencing and accumulation.
  always_comb begin
    w_state_n   = r_state;
    w_lft_s_n   = r_lft_s;
    w_rht_s_n   = r_rht_s;
    w_acc_l_n   = r_acc_l;
    w_acc_r_n   = r_acc_r;
    w_band_n    = r_band;
    w_chan_n    = r_chan;
    w_cnt_n     = r_cnt;
    w_mute_n    = r_mute;
    w_start_n   = 1'b0;
    w_lft_out_n = r_lft_out;
    w_rht_out_n = r_rht_out;
    w_out_rdy_n = 1'b0;
    w_busy_n    = r_busy;
    w_overrun_n = r_overrun | (w_frame & (r_state != S_IDLE));
    w_tmo_n     = r_tmo;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame) begin
          w_lft_s_n = lft_in;
          w_rht_s_n = rht_in;
          w_acc_l_n = '0;
          w_acc_r_n = '0;
          w_busy_n  = 1'b1;
          w_mute_n  = w_mute_in;
          w_chan_n  = 1'b0;
          if (w_first < IDX_W'(NUM_BANDS)) begin
            w_band_n  = w_first[BND_W-1:0];
            w_start_n = 1'b1;
            w_state_n = S_ISSUE;
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_n   = '0;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final timeout cycle still wins over the timeout.
        if (eng_done) begin
          w_adv = 1'b1;
          if (r_chan) w_acc_r_n = r_acc_r + w_res_ext;
          else        w_acc_l_n = r_acc_l + w_res_ext;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_adv   = 1'b1;
          w_tmo_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
        if (w_adv) begin
          if (!r_chan) begin
            w_chan_n  = 1'b1;
            w_start_n = 1'b1;
            w_state_n = S_ISSUE;
          end else if (w_next < IDX_W'(NUM_BANDS)) begin
            w_band_n  = w_next[BND_W-1:0];
            w_chan_n  = 1'b0;
            w_start_n = 1'b1;
            w_state_n = S_ISSUE;
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_lft_out_n = sat16(r_acc_l);
        w_rht_out_n = sat16(r_acc_r);
        w_out_rdy_n = 1'b1;
        w_busy_n    = 1'b0;
        w_state_n   = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_eng_sample_n = w_chan_n ? w_rht_s_n : w_lft_s_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_lft_s      <= '0;
      r_rht_s      <= '0;
      r_acc_l      <= '0;
      r_acc_r      <= '0;
      r_band       <= '0;
      r_chan       <= 1'b0;
      r_cnt        <= '0;
      r_mute       <= '0;
      r_eng_start  <= 1'b0;
      r_eng_sample <= '0;
      r_lft_out    <= '0;
      r_rht_out    <= '0;
      r_out_rdy    <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_tmo        <= 1'b0;
    end else begin
      r_valid      <= valid;
      r_lft_s      <= w_lft_s_n;
      r_rht_s      <= w_rht_s_n;
      r_acc_l      <= w_acc_l_n;
      r_acc_r      <= w_acc_r_n;
      r_band       <= w_band_n;
      r_chan       <= w_chan_n;
      r_cnt        <= w_cnt_n;
      r_mute       <= w_mute_n;
      r_eng_start  <= w_start_n;
      r_eng_sample <= w_eng_sample_n;
      r_lft_out    <= w_lft_out_n;
      r_rht_out    <= w_rht_out_n;
      r_out_rdy    <= w_out_rdy_n;
      r_busy       <= w_busy_n;
      r_overrun    <= w_overrun_n;
      r_tmo        <= w_tmo_n;
    end
  end

endmodule
